// File: rtl/cv32e41s_prefetch_ctrl.sv
// Prefetch sequencing controller: grants instruction-bus issue slots based on
// alignment-buffer room and outstanding transactions, tags in-flight responses
// for discard on a taken branch, and quiesces fetch on a halt request.
module cv32e41s_prefetch_ctrl #(
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fetch_req_i,
  input  logic       branch_i,
  input  logic       halt_i,
  output logic       halted_o,
  output logic       pf_fetch_valid_o,
  input  logic       pf_fetch_ready_i,
  output logic       pf_branch_o,
  input  logic       resp_valid_i,
  output logic       resp_keep_o,
  input  logic       buf_pop_i,
  output logic       buf_flush_o,
  output logic [2:0] outstanding_o
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam logic [2:0] MAX_C   = 3'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {RUN, HALT_WAIT, HALTED} state_e;

  state_e     state_q, state_d;
  logic [2:0] outst_q, outst_d;
  logic [2:0] discard_q, discard_d;
  logic [2:0] occ_q, occ_d;

  logic [2:0] kept_inflight;
  logic [3:0] fill;
  logic       credit;
  logic       issue_allowed;
  logic       fetch_valid;
  logic       issue;
  logic       keep;

  // Issue decision: buffer room and outstanding limit, with a branch seeing an
  // empty buffer since both the contents and the old in-flight data are dropped.
  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    kept_inflight = outst_q - discard_q;
    fill          = 4'd0;
    if (!branch_i) begin
      fill = {1'b0, occ_q} + {1'b0, kept_inflight};
    end
    credit        = (fill < {1'b0, DEPTH_C}) && (outst_q < MAX_C);
    // Leaving HALTED releases fetch in the same cycle halt_i drops.
    issue_allowed = (state_q == RUN) || ((state_q == HALTED) && !halt_i);
    fetch_valid   = issue_allowed && (fetch_req_i || branch_i) && credit;
    issue         = fetch_valid && pf_fetch_ready_i;
    // A response landing in the branch cycle belongs to the old stream.
    keep          = resp_valid_i && (discard_q == 3'd0) && !branch_i;
  end

  // Next-state for the outstanding, discard and occupancy counters.
  always_comb begin
    outst_d   = outst_q + 3'(issue) - 3'(resp_valid_i);
    discard_d = discard_q - 3'(resp_valid_i && (discard_q != 3'd0));
    occ_d     = occ_q + 3'(keep) - 3'(buf_pop_i);
    if (branch_i) begin
      // The transaction issued alongside the branch is the new target: not discarded.
      discard_d = outst_q - 3'(resp_valid_i);
      occ_d     = 3'd0;
    end
  end

  // Halt handshake: stop issuing, wait for the bus to drain, then report halted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:       if (halt_i) state_d = HALT_WAIT;
      HALT_WAIT: begin
        if (!halt_i)               state_d = RUN;
        else if (outst_d == 3'd0)  state_d = HALTED;
      end
      HALTED:    if (!halt_i) state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  // State and counter registers.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      outst_q   <= 3'd0;
      discard_q <= 3'd0;
      occ_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      occ_q     <= occ_d;
    end
  end

  // Reset holds the handshake outputs low even while inputs are active.
  assign pf_fetch_valid_o = rst_n && fetch_valid;
  assign resp_keep_o      = rst_n && keep;
  assign buf_flush_o      = rst_n && branch_i;
  assign halted_o         = rst_n && (state_q == HALTED);
  assign pf_branch_o      = branch_i;
  assign outstanding_o    = outst_q;

  // Illegal stimulus and counter range checks.
  a_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(buf_pop_i && (occ_q == 3'd0) && !keep));
  a_resp_none: assert property (@(posedge clk) disable iff (!rst_n)
    !(resp_valid_i && (outst_q == 3'd0)));
  a_outst_rng: assert property (@(posedge clk) disable iff (!rst_n) outst_q <= MAX_C);
  a_disc_rng:  assert property (@(posedge clk) disable iff (!rst_n) discard_q <= outst_q);
  a_occ_rng:   assert property (@(posedge clk) disable iff (!rst_n) occ_q <= DEPTH_C);

endmodule
